// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time, delivers it 1 cycle after ack, holds it under stall_i.
// Redirects flush in-flight fetches; PC_SEQUENCER_PERF_CNT_EN adds consumed-instruction / redirect counters.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_req_i,
  input  logic        branch_en_i,
  input  logic [31:0] dest_addr_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [15:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        flush_o,
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DISCARD = 3'd2,
    S_WAIT    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_addr;
  logic [31:0] r_inst;
  logic [15:0] r_inst_pc;
  logic        r_valid;
  logic        r_flush;

  logic        w_taken;
  logic [15:0] w_dest;
  logic        w_redirect;
  logic        w_consume;
  logic        w_ld_inst;
  logic        w_ld_addr;
  logic [15:0] w_addr_nxt;
  logic [15:0] w_pc_nxt;
  logic        w_unused_dest;

  assign w_taken       = branch_req_i & branch_en_i;
  assign w_dest        = dest_addr_i[15:0];
  assign w_unused_dest = ^dest_addr_i[31:16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_redirect   = 1'b0;
    w_consume    = 1'b0;
    w_ld_inst    = 1'b0;
    w_ld_addr    = 1'b0;
    w_addr_nxt   = r_pc;
    w_pc_nxt     = r_pc;
    imem_req_o   = 1'b0;
    halted_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
        w_ld_addr    = 1'b1;
        if (w_taken) begin
          w_redirect = 1'b1;
          w_pc_nxt   = w_dest;
          w_addr_nxt = w_dest;
        end
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (w_taken) begin
          w_redirect = 1'b1;
          w_pc_nxt   = w_dest;
          if (imem_ack_i) begin
            // Data for the old path is dropped; restart straight at the target.
            w_ld_addr  = 1'b1;
            w_addr_nxt = w_dest;
          end else begin
            w_next_state = S_DISCARD;
          end
        end else if (imem_ack_i) begin
          w_ld_inst    = 1'b1;
          w_pc_nxt     = r_addr + 16'd1;
          w_next_state = S_WAIT;
        end
      end
      S_DISCARD: begin
        imem_req_o = 1'b1;
        if (w_taken) begin
          w_redirect = 1'b1;
          w_pc_nxt   = w_dest;
        end
        if (imem_ack_i) begin
          w_next_state = S_FETCH;
          w_ld_addr    = 1'b1;
          w_addr_nxt   = w_pc_nxt;
        end
      end
      S_WAIT: begin
        if (w_taken) begin
          w_redirect   = 1'b1;
          w_pc_nxt     = w_dest;
          w_next_state = S_FETCH;
          w_ld_addr    = 1'b1;
          w_addr_nxt   = w_dest;
        end else if (!stall_i) begin
          w_consume = 1'b1;
          if (halt_i) begin
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_FETCH;
            w_ld_addr    = 1'b1;
            w_addr_nxt   = r_pc;
          end
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc      <= RESET_PC;
      r_addr    <= 16'h0000;
      r_inst    <= 32'h0000_0000;
      r_inst_pc <= 16'h0000;
      r_valid   <= 1'b0;
      r_flush   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_flush <= w_redirect;
      if (w_ld_addr) begin
        r_addr <= w_addr_nxt;
      end
      if (w_ld_inst) begin
        r_inst    <= imem_data_i;
        r_inst_pc <= r_addr;
        r_valid   <= 1'b1;
      end else if (w_redirect || w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign imem_addr_o  = r_addr;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign inst_valid_o = r_valid;
  assign flush_o      = r_flush;

`ifdef PC_SEQUENCER_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redirect_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_cnt    <= 32'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      if (w_consume) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_redirect) begin
        r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o    = r_fetch_cnt;
  assign redirect_cnt_o = r_redirect_cnt;
`else
  assign fetch_cnt_o    = 32'd0;
  assign redirect_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written counter/throughput sequence,
// and a randomized run checked against an instruction-stream reference model.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        branch_req_i;
  logic        branch_en_i;
  logic [31:0] dest_addr_i;
  logic        stall_i;
  logic        halt_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] inst_o;
  logic [15:0] inst_pc_o;
  logic        inst_valid_o;
  logic        flush_o;
  logic        halted_o;
  logic [31:0] fetch_cnt_o;
  logic [31:0] redirect_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  pc_sequencer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .branch_req_i  (branch_req_i),
    .branch_en_i   (branch_en_i),
    .dest_addr_i   (dest_addr_i),
    .stall_i       (stall_i),
    .halt_i        (halt_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_valid_o  (inst_valid_o),
    .flush_o       (flush_o),
    .halted_o      (halted_o),
    .fetch_cnt_o   (fetch_cnt_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ack;
    logic        brq;
    logic        bre;
    logic [31:0] dest;
    logic        stall;
    logic        halt;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic        e_flush;
    logic        e_halted;
    logic        e_izero;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ack, input logic brq, input logic bre,
                              input logic [31:0] dest, input logic stall, input logic halt,
                              input logic e_req, input logic [15:0] e_addr, input logic e_valid,
                              input logic [15:0] e_pc, input logic e_flush, input logic e_halted,
                              input logic e_izero);
    vec_t v;
    v.rst = rst; v.ack = ack; v.brq = brq; v.bre = bre; v.dest = dest; v.stall = stall;
    v.halt = halt; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_flush = e_flush; v.e_halted = e_halted; v.e_izero = e_izero;
    return v;
  endfunction

  task automatic drive_idle();
    branch_req_i = 1'b0;
    branch_en_i  = 1'b0;
    dest_addr_i  = 32'h0;
    stall_i      = 1'b0;
    halt_i       = 1'b0;
    imem_ack_i   = 1'b0;
    imem_data_i  = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_idle();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  vec_t vecs[29];

  initial begin
    logic [15:0] exp_next;
    logic        exp_flush;
    logic        hold_inst;
    logic [31:0] hold_dat;
    logic [15:0] hold_pc;
    logic        hold_req;
    logic [15:0] hold_addr;
    logic        taken;
    int          wait_cnt;
    int          delay;
    int          consumed;

    rst_i = 1'b1;
    drive_idle();

    //            rst ack brq bre dest           st h | req addr     v pc       fl hl iz
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[1]  = mk(0, 1, 0, 0, 32'h0,          0, 0,  1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0000, 1, 16'h0000, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 32'h77,         0, 0,  1, 16'h0001, 0, 16'h0000, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,          1, 0,  0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,          1, 0,  0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,          1, 0,  0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,          1, 0,  0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,          1, 0,  0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0001, 1, 16'h0001, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 32'hABCD_0040,  0, 0,  1, 16'h0002, 0, 16'h0001, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,          0, 0,  1, 16'h0002, 0, 16'h0001, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 32'h0,          0, 0,  1, 16'h0002, 0, 16'h0001, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, 0, 32'h0,          0, 0,  1, 16'h0002, 0, 16'h0001, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 0, 32'h0,          0, 0,  1, 16'h0040, 0, 16'h0001, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 1, 32'h0000_FFFF,  1, 1,  0, 16'h0040, 1, 16'h0040, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 0, 32'h0,          0, 0,  1, 16'hFFFF, 0, 16'h0040, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'hFFFF, 1, 16'hFFFF, 0, 0, 0);
    vecs[18] = mk(0, 1, 1, 1, 32'h0000_0123,  0, 0,  1, 16'h0000, 0, 16'hFFFF, 0, 0, 0);
    vecs[19] = mk(0, 1, 0, 0, 32'h0,          0, 0,  1, 16'h0123, 0, 16'hFFFF, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 32'h0,          0, 1,  0, 16'h0123, 1, 16'h0123, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 1, 32'h0000_0200,  0, 0,  0, 16'h0123, 0, 16'h0123, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0123, 0, 16'h0123, 0, 1, 0);
    vecs[23] = mk(1, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0123, 0, 16'h0123, 0, 1, 0);
    vecs[24] = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[25] = mk(1, 0, 0, 0, 32'h0,          0, 0,  1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[26] = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[27] = mk(0, 1, 0, 0, 32'h0,          0, 0,  1, 16'h0000, 0, 16'h0000, 0, 0, 1);
    vecs[28] = mk(0, 0, 0, 0, 32'h0,          0, 0,  0, 16'h0000, 1, 16'h0000, 0, 0, 0);

    // Directed table: outputs checked first, then this row's inputs applied for the next edge.
    do_reset();
    for (int i = 0; i < 29; i++) begin
      chk($sformatf("vec%0d_req", i),    imem_req_o,   vecs[i].e_req);
      chk($sformatf("vec%0d_addr", i),   imem_addr_o,  vecs[i].e_addr);
      chk($sformatf("vec%0d_valid", i),  inst_valid_o, vecs[i].e_valid);
      chk($sformatf("vec%0d_pc", i),     inst_pc_o,    vecs[i].e_pc);
      chk($sformatf("vec%0d_flush", i),  flush_o,      vecs[i].e_flush);
      chk($sformatf("vec%0d_halted", i), halted_o,     vecs[i].e_halted);
      if (vecs[i].e_izero) chk($sformatf("vec%0d_inst0", i), inst_o, 32'h0);
      else if (vecs[i].e_valid) chk($sformatf("vec%0d_inst", i), inst_o, mem_word(vecs[i].e_pc));
      rst_i        = vecs[i].rst;
      imem_ack_i   = vecs[i].ack;
      imem_data_i  = mem_word(imem_addr_o);
      branch_req_i = vecs[i].brq;
      branch_en_i  = vecs[i].bre;
      dest_addr_i  = vecs[i].dest;
      stall_i      = vecs[i].stall;
      halt_i       = vecs[i].halt;
      @(negedge clk_i);
    end

    // Zero-latency memory: 10 back-to-back instructions, then two redirects while stalled.
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      if (c == 0) begin
        chk("cnt_reset_fetch", fetch_cnt_o, 32'd0);
        chk("cnt_reset_redir", redirect_cnt_o, 32'd0);
      end
      if (c <= 20) begin
        chk($sformatf("seq%0d_valid", c), inst_valid_o, (c >= 2 && c % 2 == 0) ? 1 : 0);
        if (c >= 2 && c % 2 == 0) chk($sformatf("seq%0d_pc", c), inst_pc_o, c / 2 - 1);
      end
      if (c == 23 || c == 24) chk($sformatf("seq%0d_flush", c), flush_o, 1);
      if (c == 25) chk("seq25_pc", inst_pc_o, 16'h0310);
      if (c == 26) begin
`ifdef PC_SEQUENCER_PERF_CNT_EN
        chk("cnt_fetch", fetch_cnt_o, 32'd10);
        chk("cnt_redir", redirect_cnt_o, 32'd2);
`else
        chk("cnt_fetch_tied", fetch_cnt_o, 32'd0);
        chk("cnt_redir_tied", redirect_cnt_o, 32'd0);
`endif
      end
      imem_ack_i   = imem_req_o;
      imem_data_i  = mem_word(imem_addr_o);
      stall_i      = (c >= 21);
      branch_req_i = (c == 22 || c == 23);
      branch_en_i  = (c == 22 || c == 23);
      dest_addr_i  = (c == 22) ? 32'h0000_0300 : 32'h0000_0310;
      @(negedge clk_i);
    end

    // Randomized run: consumed instructions must follow the sequential/redirect stream.
    do_reset();
    exp_next  = 16'h0000;
    exp_flush = 1'b0;
    hold_inst = 1'b0;
    hold_dat  = 32'h0;
    hold_pc   = 16'h0;
    hold_req  = 1'b0;
    hold_addr = 16'h0;
    wait_cnt  = 0;
    delay     = $urandom_range(0, 3);
    consumed  = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_flush", flush_o, exp_flush);
      chk("rnd_halted", halted_o, 0);
      if (hold_inst) begin
        chk("rnd_hold_valid", inst_valid_o, 1);
        chk("rnd_hold_inst", inst_o, hold_dat);
        chk("rnd_hold_pc", inst_pc_o, hold_pc);
      end
      if (hold_req) begin
        chk("rnd_hold_req", imem_req_o, 1);
        chk("rnd_hold_addr", imem_addr_o, hold_addr);
      end
      branch_req_i = ($urandom_range(0, 7) == 0);
      branch_en_i  = $urandom_range(0, 1);
      dest_addr_i  = $urandom;
      stall_i      = ($urandom_range(0, 2) == 0);
      halt_i       = 1'b0;
      imem_ack_i   = imem_req_o && (wait_cnt >= delay);
      imem_data_i  = mem_word(imem_addr_o);
      taken        = branch_req_i && branch_en_i;
      if (inst_valid_o && !stall_i && !taken) begin
        chk("rnd_pc", inst_pc_o, exp_next);
        chk("rnd_inst", inst_o, mem_word(exp_next));
        exp_next = exp_next + 16'd1;
        consumed++;
      end
      if (taken) exp_next = dest_addr_i[15:0];
      exp_flush = taken;
      hold_inst = inst_valid_o && stall_i && !taken;
      hold_dat  = inst_o;
      hold_pc   = inst_pc_o;
      hold_req  = imem_req_o && !imem_ack_i;
      hold_addr = imem_addr_o;
      if (imem_req_o && imem_ack_i) begin
        wait_cnt = 0;
        delay    = $urandom_range(0, 3);
      end else if (imem_req_o) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      @(negedge clk_i);
    end
    chk("rnd_progress", (consumed > 300) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
